// File: rtl/banked_matrix_mem.sv
// banked_matrix_mem: parametrised word store for matrix operands and results.
// It sits between the matrix-multiply controller and the MAC datapath.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset; starts a zero-fill of the array
//   clear     request a zero-fill of the whole array (taken only when idle)
//   busy      high while the zero-fill runs; write and read ports are ignored
//   wr_en     write strobe
//   wr_addr   write address; addresses >= DEPTH are dropped
//   wr_data   write data
//   rd_en     read request
//   rd_addr   read address; addresses >= DEPTH return zero
//   rd_data   registered read data; holds between reads
//   rd_valid  one-cycle pulse marking rd_data as the answer to last cycle's rd_en
//
// The array has no reset and a single write port shared by the clear engine and
// the write port, so it can map onto block RAM. The clear engine writes one word
// per cycle.
module banked_matrix_mem #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DEPTH    = 1 << ADDR_W,
   parameter bit          WR_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   output logic              busy,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid
);

   localparam logic [ADDR_W:0]   DepthExt = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LastPtr  = ADDR_W'(DEPTH - 1);

   typedef enum logic [0:0] {StIdle, StClear} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              wr_in_range;
   logic              rd_in_range;
   logic              port_we;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   // Write-port and clear-engine arbitration onto the single array write port.
   always_comb begin
      wr_in_range = ({1'b0, wr_addr} < DepthExt);
      rd_in_range = ({1'b0, rd_addr} < DepthExt);
      // The edge that accepts clear performs no array write.
      port_we     = (state_q == StIdle) && !clear && wr_en && wr_in_range;
      mem_we      = !rst && ((state_q == StClear) || port_we);
      if (state_q == StClear) begin
         mem_waddr = clr_ptr_q;
         mem_wdata = '0;
      end else begin
         mem_waddr = wr_addr;
         mem_wdata = wr_data;
      end
   end

   // Next state for the clear engine.
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      unique case (state_q)
         StIdle: begin
            if (clear) begin
               state_d   = StClear;
               clr_ptr_d = '0;
            end
         end
         StClear: begin
            // clear is ignored here: a running fill never restarts.
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == LastPtr) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d   = StClear;
            clr_ptr_d = '0;
         end
      endcase
   end

   // Read response. mem_q still holds the pre-write word at this edge, so the
   // old-data case needs no extra logic.
   always_comb begin
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      if ((state_q == StIdle) && rd_en) begin
         rd_valid_d = 1'b1;
         if (!rd_in_range) begin
            rd_data_d = '0;
         end else if (WR_FIRST && port_we && (wr_addr == rd_addr)) begin
            rd_data_d = wr_data;
         end else begin
            rd_data_d = mem_q[rd_addr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StClear;
         clr_ptr_q  <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_ptr_q  <= clr_ptr_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign busy     = (state_q == StClear);
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

endmodule
